// File: rtl/lsu_axil_wide.sv
// AXI-Lite load/store unit (DATA_W 32 or 64) with byte-lane alignment and fault reporting.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of issuing them on the bus.
module lsu_axil_wide #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                lsu_valid,
  output logic                lsu_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_data,
  input  logic [1:0]          lsu_mode,
  input  logic [2:0]          lsu_op,
  input  logic [ADDR_W-1:0]   Next_pc,
  input  logic [4:0]          Rw,
  input  logic [DATA_W-1:0]   result,
  input  logic                regwr,
  output logic [ADDR_W-1:0]   Next_pc_out,
  output logic [4:0]          Rw_out,
  output logic [DATA_W-1:0]   result_out,
  output logic                regwr_out,
  output logic                fault_out,
  output logic [1:0]          fault_cause_out,
  output logic                wbu_valid,
  input  logic                wbu_ready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {ACCEPT, AR, R, AWW, B, WB} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  addr_r;
  logic [2:0]         op_r;
  logic [DATA_W-1:0]  result_r;
  logic               regwr_r;
  logic               aw_done;
  logic               w_done;
  logic [OFF_W-1:0]   req_off;
  logic               req_mis;
  logic               aw_hs;
  logic               w_hs;

  // Access size in bytes; d and wu collapse to a 4-byte word on a 32-bit bus.
  function automatic logic [3:0] size_of(input logic [2:0] op);
    case (op)
      3'b000, 3'b100: size_of = 4'd1;
      3'b001, 3'b101: size_of = 4'd2;
      3'b011:         size_of = (DATA_W == 64) ? 4'd8 : 4'd4;
      default:        size_of = 4'd4;
    endcase
  endfunction

  function automatic logic [STRB_W-1:0] lane_strb(input logic [2:0] op, input logic [OFF_W-1:0] off);
    logic [15:0] m;
    m = (16'd1 << size_of(op)) - 16'd1;
    m = m << off;
    lane_strb = m[STRB_W-1:0];
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [OFF_W-1:0] off);
    misaligned = (4'(off) & (size_of(op) - 4'd1)) != 4'd0;
  endfunction

  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] rdata,
                                                 input logic [2:0] op,
                                                 input logic [OFF_W-1:0] off);
    logic [DATA_W-1:0] rsh;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic signed [31:0] sw;
    rsh = rdata >> {off, 3'b000};
    sb  = rsh[7:0];
    sh  = rsh[15:0];
    sw  = rsh[31:0];
    case (op)
      3'b000:  load_ext = DATA_W'(sb);
      3'b001:  load_ext = DATA_W'(sh);
      3'b010:  load_ext = DATA_W'(sw);
      3'b100:  load_ext = DATA_W'(rsh[7:0]);
      3'b101:  load_ext = DATA_W'(rsh[15:0]);
      3'b110:  load_ext = (DATA_W == 64) ? DATA_W'(rsh[31:0]) : DATA_W'(sw);
      default: load_ext = rsh;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] addr_ext(input logic [ADDR_W-1:0] a);
    addr_ext = DATA_W'(a);
  endfunction

  assign req_off = lsu_addr[OFF_W-1:0];
  assign req_mis = misaligned(lsu_op, req_off);
  assign aw_hs   = m_awvalid && m_awready;
  assign w_hs    = m_wvalid && m_wready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ACCEPT;
      lsu_ready       <= 1'b1;
      m_arvalid       <= 1'b0;
      m_rready        <= 1'b0;
      m_awvalid       <= 1'b0;
      m_wvalid        <= 1'b0;
      m_bready        <= 1'b0;
      wbu_valid       <= 1'b0;
      aw_done         <= 1'b0;
      w_done          <= 1'b0;
      addr_r          <= '0;
      op_r            <= '0;
      result_r        <= '0;
      regwr_r         <= 1'b0;
      m_araddr        <= '0;
      m_awaddr        <= '0;
      m_wdata         <= '0;
      m_wstrb         <= '0;
      Next_pc_out     <= '0;
      Rw_out          <= '0;
      result_out      <= '0;
      regwr_out       <= 1'b0;
      fault_out       <= 1'b0;
      fault_cause_out <= 2'b00;
    end else begin
      case (state)
        ACCEPT: if (lsu_valid) begin
          lsu_ready   <= 1'b0;
          addr_r      <= lsu_addr;
          op_r        <= lsu_op;
          result_r    <= result;
          regwr_r     <= regwr;
          m_araddr    <= lsu_addr;
          m_awaddr    <= lsu_addr;
          m_wdata     <= lsu_data << {req_off, 3'b000};
          m_wstrb     <= lane_strb(lsu_op, req_off);
          Next_pc_out <= Next_pc;
          Rw_out      <= Rw;
          if (lsu_mode[0] && TRAP_EN && req_mis) begin
            // mode[1] distinguishes store (11) from load (01) in the cause code
            state           <= WB;
            wbu_valid       <= 1'b1;
            fault_out       <= 1'b1;
            fault_cause_out <= {1'b1, lsu_mode[1]};
            regwr_out       <= 1'b0;
            result_out      <= addr_ext(lsu_addr);
          end else if (lsu_mode == 2'b01) begin
            state     <= AR;
            m_arvalid <= 1'b1;
          end else if (lsu_mode == 2'b11) begin
            state     <= AWW;
            m_awvalid <= 1'b1;
            m_wvalid  <= 1'b1;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
          end else begin
            state           <= WB;
            wbu_valid       <= 1'b1;
            fault_out       <= 1'b0;
            fault_cause_out <= 2'b00;
            regwr_out       <= regwr;
            result_out      <= result;
          end
        end
        AR: if (m_arready) begin
          m_arvalid <= 1'b0;
          m_rready  <= 1'b1;
          state     <= R;
        end
        R: if (m_rvalid) begin
          m_rready        <= 1'b0;
          wbu_valid       <= 1'b1;
          state           <= WB;
          fault_cause_out <= 2'b00;
          if (m_rresp != 2'b00) begin
            fault_out  <= 1'b1;
            regwr_out  <= 1'b0;
            result_out <= addr_ext(addr_r);
          end else begin
            fault_out  <= 1'b0;
            regwr_out  <= regwr_r;
            result_out <= load_ext(m_rdata, op_r, addr_r[OFF_W-1:0]);
          end
        end
        AWW: begin
          // Address and data channels complete independently, possibly in the same cycle.
          if (aw_hs) begin
            m_awvalid <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            m_wvalid <= 1'b0;
            w_done   <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            m_bready <= 1'b1;
            state    <= B;
          end
        end
        B: if (m_bvalid) begin
          m_bready  <= 1'b0;
          wbu_valid <= 1'b1;
          state     <= WB;
          if (m_bresp != 2'b00) begin
            fault_out       <= 1'b1;
            fault_cause_out <= 2'b01;
            regwr_out       <= 1'b0;
            result_out      <= addr_ext(addr_r);
          end else begin
            fault_out       <= 1'b0;
            fault_cause_out <= 2'b00;
            regwr_out       <= regwr_r;
            result_out      <= result_r;
          end
        end
        WB: if (wbu_ready) begin
          wbu_valid <= 1'b0;
          lsu_ready <= 1'b1;
          state     <= ACCEPT;
        end
        default: begin
          state     <= ACCEPT;
          lsu_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule
